// File: rtl/data_transfer_pkg.sv
// Shared types and limits for the data transfer link.
package data_transfer_pkg;

    localparam int DATA_W    = 8;
    localparam int MAX_DEPTH = 16;
    localparam int LVL_W     = $clog2(MAX_DEPTH + 1);

    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/data_transfer_fifo.sv
// Circular buffer storage with wrapping pointers and a registered head word.
module data_transfer_fifo
    import data_transfer_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [LVL_W-1:0] level,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_q, head_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // The head register is reloaded with whatever will be oldest after this
    // edge; when the buffer drains it simply keeps the last word shown.
    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        head_d   = head_q;
        if (pop) begin
            if (level > LVL_W'(1))
                head_d = mem_q[rd_ptr_d];
            else if (push)
                head_d = wr_data;
        end else if (level == '0 && push) begin
            head_d = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= wr_data;
    end

    assign head = head_q;

endmodule

// File: rtl/data_transfer_link.sv
// Valid/ready buffered link: handshake, occupancy and optional traffic counters.
// Define DATA_TRANSFER_STATS_EN to add in_count/out_count outputs.
module data_transfer_link
    import data_transfer_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_in_valid,
    output logic             ready_to_receive,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_valid,
    input  logic             sink_ready,
`ifdef DATA_TRANSFER_STATS_EN
    output logic [4:0]       level,
    output logic [15:0]      in_count,
    output logic [15:0]      out_count
`else
    output logic [4:0]       level
`endif
);

    logic [LVL_W-1:0] level_q, level_d;
    logic             push, pop;

    // Handshake depends only on the registered level, so no input reaches
    // ready_to_receive or data_out_valid combinationally.
    assign ready_to_receive = (level_q < LVL_W'(DEPTH));
    assign data_out_valid   = (level_q != '0);
    assign push             = data_in_valid && ready_to_receive;
    assign pop              = data_out_valid && sink_ready;
    assign level            = level_q;

    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + 1'b1;
        else if (pop && !push)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            level_q <= '0;
        else
            level_q <= level_d;
    end

    data_transfer_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (data_in),
        .level   (level_q),
        .head    (data_out)
    );

`ifdef DATA_TRANSFER_STATS_EN
    logic [15:0] in_count_q, in_count_d;
    logic [15:0] out_count_q, out_count_d;

    always_comb begin
        in_count_d  = in_count_q + 16'(push);
        out_count_d = out_count_q + 16'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_count_q  <= '0;
            out_count_q <= '0;
        end else begin
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_count  = in_count_q;
    assign out_count = out_count_q;
`endif

endmodule

// File: tb/tb_data_transfer_link.sv
// Directed bench for data_transfer_link (DEPTH=2); stats checked when
// DATA_TRANSFER_STATS_EN is defined.
module tb_data_transfer_link;
    import data_transfer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    data_t       data_in = '0;
    logic        data_in_valid = 1'b0;
    logic        ready_to_receive;
    data_t       data_out;
    logic        data_out_valid;
    logic        sink_ready = 1'b0;
    logic [4:0]  level;
`ifdef DATA_TRANSFER_STATS_EN
    logic [15:0] in_count;
    logic [15:0] out_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_transfer_link #(.WIDTH(8), .DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .data_in          (data_in),
        .data_in_valid    (data_in_valid),
        .ready_to_receive (ready_to_receive),
        .data_out         (data_out),
        .data_out_valid   (data_out_valid),
        .sink_ready       (sink_ready),
`ifdef DATA_TRANSFER_STATS_EN
        .level            (level),
        .in_count         (in_count),
        .out_count        (out_count)
`else
        .level            (level)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held 10 cycles
        check("rst_hold_valid", 32'(data_out_valid), 0);
        check("rst_hold_rdy", 32'(ready_to_receive), 1);
        repeat (10) tick();
        rst = 1'b0;
        check("rst_level", 32'(level), 0);
        check("rst_valid", 32'(data_out_valid), 0);
        check("rst_rdy", 32'(ready_to_receive), 1);
        check("rst_dout", 32'(data_out), 0);

        // stream 0..9 with push and pop every cycle
        sink_ready    = 1'b1;
        data_in_valid = 1'b1;
        data_in       = 8'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("stream_dout%0d", i), 32'(data_out), 32'(i));
            check($sformatf("stream_vld%0d", i), 32'(data_out_valid), 1);
            check($sformatf("stream_rdy%0d", i), 32'(ready_to_receive), 1);
            check($sformatf("stream_lvl%0d", i), 32'(level), 1);
            data_in = data_t'(i + 1);
        end
        data_in_valid = 1'b0;
        tick();
        check("drain_level", 32'(level), 0);
        check("drain_valid", 32'(data_out_valid), 0);
        check("drain_hold", 32'(data_out), 32'h09);
        tick();
        check("empty_no_underflow", 32'(level), 0);

        // backpressure: third word refused
        sink_ready    = 1'b0;
        data_in_valid = 1'b1;
        data_in       = 8'h0A;
        tick();
        check("bp_lvl1", 32'(level), 1);
        check("bp_dout1", 32'(data_out), 32'h0A);
        data_in = 8'h0B;
        tick();
        check("bp_lvl2", 32'(level), 2);
        check("bp_rdy_low", 32'(ready_to_receive), 0);
        data_in = 8'h0C;
        tick();
        check("bp_refuse_lvl", 32'(level), 2);
        check("bp_head", 32'(data_out), 32'h0A);
        data_in_valid = 1'b0;
        sink_ready    = 1'b1;
        tick();
        check("bp_pop1_dout", 32'(data_out), 32'h0B);
        check("bp_pop1_lvl", 32'(level), 1);
        tick();
        check("bp_pop2_lvl", 32'(level), 0);
        check("bp_pop2_hold", 32'(data_out), 32'h0B);

        // full plus pop: pop happens, push refused
        sink_ready    = 1'b0;
        data_in_valid = 1'b1;
        data_in       = 8'h11;
        tick();
        data_in = 8'h22;
        tick();
        check("full_lvl", 32'(level), 2);
        data_in    = 8'h33;
        sink_ready = 1'b1;
        tick();
        check("fullpop_lvl", 32'(level), 1);
        check("fullpop_dout", 32'(data_out), 32'h22);
        data_in_valid = 1'b0;
        tick();
        check("fullpop_drain_lvl", 32'(level), 0);
        check("fullpop_drain_dout", 32'(data_out), 32'h22);

        // asynchronous reset mid-stream
        sink_ready    = 1'b0;
        data_in_valid = 1'b1;
        data_in       = 8'h44;
        tick();
        data_in = 8'h55;
        tick();
        check("mid_lvl", 32'(level), 2);
        data_in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(data_out_valid), 0);
        check("arst_level", 32'(level), 0);
        check("arst_dout", 32'(data_out), 0);
        check("arst_rdy", 32'(ready_to_receive), 1);
        tick();
        rst           = 1'b0;
        data_in_valid = 1'b1;
        data_in       = 8'h66;
        tick();
        check("first_push_lvl", 32'(level), 1);
        check("first_push_dout", 32'(data_out), 32'h66);
        data_in_valid = 1'b0;

`ifdef DATA_TRANSFER_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("stats_clr_in", 32'(in_count), 0);
        check("stats_clr_out", 32'(out_count), 0);
        sink_ready    = 1'b1;
        data_in_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            data_in = data_t'(i);
            tick();
        end
        data_in_valid = 1'b0;
        tick();
        check("stats_in", 32'(in_count), 4464);
        check("stats_out", 32'(out_count), 4464);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
